// File: rtl/riscv_defs_pkg.sv
// Shared RV32 front-end definitions.
// Fetch constants and the IF->ID bundle.
package riscv_defs_pkg;
  localparam int XLEN = 32;
  localparam int IMEM_AW = 14;
  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [XLEN-1:0] INST_NOP = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] inst;
  } if_id_t;

  function automatic logic [XLEN-1:0] word_align(
    input logic [XLEN-1:0] a
  );
    return {a[XLEN-1:2], 2'b00};
  endfunction
endpackage

// File: rtl/if_prefetch_unit_if.sv
// Fetch-unit bus: redirect, IMEM port and
// the decode valid/ready handshake.
interface if_prefetch_unit_if;
  import riscv_defs_pkg::*;
  logic redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic id_ready;
  logic if_valid;
  logic [XLEN-1:0] if_pc;
  logic [XLEN-1:0] if_inst;
  logic [XLEN-1:0] DO_im;
  logic [IMEM_AW-1:0] A_im;
  logic OE_im;

  modport master (
    input redirect_valid, redirect_pc,
    input id_ready, DO_im,
    output if_valid, if_pc, if_inst,
    output A_im, OE_im
  );
  modport slave (
    output redirect_valid, redirect_pc,
    output id_ready, DO_im,
    input if_valid, if_pc, if_inst,
    input A_im, OE_im
  );
endinterface

// File: rtl/if_prefetch_unit_inst_fifo.sv
// Prefetch queue of {pc, inst} entries.
// Flush clears pointers and count only.
module inst_fifo
  import riscv_defs_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int PW = $clog2(DEPTH),
  parameter int CW = PW + 1
) (
  input  logic clk,
  input  logic rst,
  input  logic i_push,
  input  logic i_pop,
  input  logic i_flush,
  input  if_id_t i_data,
  output if_id_t o_head,
  output logic [CW-1:0] o_count,
  output logic o_empty
);
  logic [PW-1:0] r_wptr;
  logic [PW-1:0] r_rptr;
  logic [CW-1:0] r_count;
  if_id_t r_mem [DEPTH];
  logic w_pop;
  logic w_full;

  assign o_empty = (r_count == '0);
  assign w_full = (r_count == CW'(DEPTH));
  assign w_pop = i_pop && !o_empty;
  assign o_head = r_mem[r_rptr];
  assign o_count = r_count;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_count <= '0;
      for (int i = 0; i < DEPTH; i++)
        r_mem[i] <= '0;
    end else if (i_flush) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_count <= '0;
    end else begin
      if (i_push) begin
        r_mem[r_wptr] <= i_data;
        r_wptr <= r_wptr + 1'b1;
      end
      if (w_pop)
        r_rptr <= r_rptr + 1'b1;
      unique case ({i_push, w_pop})
        2'b10: r_count <= r_count + 1'b1;
        2'b01: r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Issue credits must make this unreachable.
  always_ff @(posedge clk) begin
    if (rst && i_push && !i_flush)
      assert (!w_full || w_pop);
  end
endmodule

// File: rtl/if_prefetch_unit.sv
// IF prefetch: issues IMEM reads against FIFO
// credits and queues returned words for decode.
module if_prefetch_unit
  import riscv_defs_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
  input logic clk,
  input logic rst,
  if_prefetch_unit_if.master bus
);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int UW = CW + 1;

  logic [XLEN-1:0] r_fetch_pc;
  logic [XLEN-1:0] r_req_pc;
  logic r_inflight;

  logic [CW-1:0] w_count;
  logic [UW-1:0] w_used;
  logic w_empty;
  logic w_issue;
  logic w_kill;
  logic w_push;
  logic w_pop;
  if_id_t w_head;
  if_id_t w_ret;

  assign w_used = UW'(w_count) + UW'(r_inflight);
  assign w_issue = rst && !bus.redirect_valid
                && (w_used < UW'(DEPTH));
  // A redirect during the return cycle kills it.
  assign w_kill = bus.redirect_valid;
  assign w_push = r_inflight && !w_kill;
  assign w_pop = bus.if_valid && bus.id_ready;
  assign w_ret = '{pc: r_req_pc, inst: bus.DO_im};

  inst_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk(clk),
    .rst(rst),
    .i_push(w_push),
    .i_pop(w_pop),
    .i_flush(bus.redirect_valid),
    .i_data(w_ret),
    .o_head(w_head),
    .o_count(w_count),
    .o_empty(w_empty)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_fetch_pc <= RESET_PC;
      r_req_pc <= '0;
      r_inflight <= 1'b0;
    end else if (bus.redirect_valid) begin
      r_fetch_pc <= word_align(bus.redirect_pc);
      r_inflight <= 1'b0;
    end else begin
      r_inflight <= w_issue;
      if (w_issue) begin
        r_fetch_pc <= r_fetch_pc + 32'd4;
        r_req_pc <= r_fetch_pc;
      end
    end
  end

  assign bus.OE_im = w_issue;
  assign bus.A_im = rst ? r_fetch_pc[15:2]
                        : RESET_PC[15:2];
  assign bus.if_valid = rst && !w_empty;
  assign bus.if_pc = rst ? w_head.pc : '0;
  assign bus.if_inst = rst ? w_head.inst : '0;
endmodule
